// File: rtl/mmcm_drp_cfg.sv
// DRP reconfiguration master for the HDMI pixel-clock MMCM: queued register RMWs applied under MMCM reset.
// Optional write-verify readback enabled by defining MMCM_DRP_VERIFY_EN.
module mmcm_drp_cfg #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DRDY_TIMEOUT = 255,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [6:0]  wr_addr,
  input  logic [15:0] wr_mask,
  input  logic [15:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        full,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [63:0] reconfig_to_pll,
  input  logic [63:0] reconfig_from_pll
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned MAXT   = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAXT + 1);
  localparam int unsigned SETTLE = 4;

  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE - 1);

  typedef enum logic [3:0] {
    IDLE,
    ASSERT_RST,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
`ifdef MMCM_DRP_VERIFY_EN
    VF_REQ,
    VF_WAIT,
`endif
    NEXT,
    RELEASE,
    LOCK_WAIT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [6:0]  q_addr [DEPTH];
  logic [15:0] q_mask [DEPTH];
  logic [15:0] q_data [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   q_cnt_q, q_cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          push, pop, flush;
  logic          err_set;
  logic [1:0]    err_set_code;

  logic          full_q, full_d, busy_q, busy_d, done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          den_q, den_d, dwe_q, dwe_d, rst_q, rst_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [15:0]   din_q, din_d;

  logic [15:0] dout;
  logic        drdy, locked;
  logic        unused_from_pll;

  assign dout            = reconfig_from_pll[15:0];
  assign drdy            = reconfig_from_pll[16];
  assign locked          = reconfig_from_pll[17];
  assign unused_from_pll = ^reconfig_from_pll[63:18];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    flush        = 1'b0;
    err_set      = 1'b0;
    err_set_code = '0;
    unique case (state_q)
      IDLE:       if (start) state_d = (q_cnt_q == '0) ? DONE : ASSERT_RST;
      ASSERT_RST: state_d = RD_REQ;
      RD_REQ:     state_d = RD_WAIT;
      RD_WAIT: begin
        if (drdy) state_d = WR_REQ;
        else if (tmr_q == DRDY_LAST) begin
          state_d = IDLE; flush = 1'b1; err_set = 1'b1; err_set_code = 2'b01;
        end
      end
      WR_REQ:     state_d = WR_WAIT;
      WR_WAIT: begin
`ifdef MMCM_DRP_VERIFY_EN
        if (drdy) state_d = VF_REQ;
`else
        if (drdy) state_d = NEXT;
`endif
        else if (tmr_q == DRDY_LAST) begin
          state_d = IDLE; flush = 1'b1; err_set = 1'b1; err_set_code = 2'b01;
        end
      end
`ifdef MMCM_DRP_VERIFY_EN
      VF_REQ:     state_d = VF_WAIT;
      VF_WAIT: begin
        if (drdy) begin
          if (dout != din_q) begin
            state_d = IDLE; flush = 1'b1; err_set = 1'b1; err_set_code = 2'b11;
          end else begin
            state_d = NEXT;
          end
        end else if (tmr_q == DRDY_LAST) begin
          state_d = IDLE; flush = 1'b1; err_set = 1'b1; err_set_code = 2'b01;
        end
      end
`endif
      NEXT:       state_d = (q_cnt_q > (AW + 1)'(1)) ? RD_REQ : RELEASE;
      // Reset is already released on entry; locked is not looked at until SETTLE cycles pass
      RELEASE:    if (tmr_q == SETL_LAST) state_d = LOCK_WAIT;
      LOCK_WAIT: begin
        if (locked) state_d = DONE;
        else if (tmr_q == LOCK_LAST) begin
          state_d = IDLE; err_set = 1'b1; err_set_code = 2'b10;
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Queue pointers and timeout counter
  always_comb begin
    push     = wr && !busy_q && !full_q;
    pop      = (state_q == NEXT);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_cnt_d  = q_cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      q_cnt_d  = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      q_cnt_d  = q_cnt_q - 1'b1;
    end else if (push) begin
      q_cnt_d  = q_cnt_q + 1'b1;
    end
    full_d = (q_cnt_d == DEPTH_C);

    tmr_d = tmr_q;
    if (state_d != state_q) tmr_d = '0;
    else if (state_q != IDLE) tmr_d = tmr_q + 1'b1;
  end

  // Output logic: registered outputs follow the state being entered
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == DONE);
    rst_d   = !(state_d inside {IDLE, RELEASE, LOCK_WAIT, DONE});
    den_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
`ifdef MMCM_DRP_VERIFY_EN
    den_d   = den_d || (state_d == VF_REQ);
`endif
    dwe_d   = (state_d == WR_REQ);
    // rd_ptr_d so that NEXT -> RD_REQ already addresses the following entry
    daddr_d = (state_d == RD_REQ) ? q_addr[rd_ptr_d] : daddr_q;
    din_d   = din_q;
    if (state_q == RD_WAIT && drdy)
      din_d = (dout & q_mask[rd_ptr_q]) | (q_data[rd_ptr_q] & ~q_mask[rd_ptr_q]);

    err_d      = err_q;
    err_code_d = err_code_q;
    if (state_q == IDLE && start) begin
      err_d      = 1'b0;
      err_code_d = '0;
    end else if (err_set) begin
      err_d      = 1'b1;
      err_code_d = err_set_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_cnt_q    <= '0;
      full_q     <= 1'b0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      rst_q      <= 1'b0;
      daddr_q    <= '0;
      din_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_cnt_q    <= q_cnt_d;
      full_q     <= full_d;
      tmr_q      <= tmr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      rst_q      <= rst_d;
      daddr_q    <= daddr_d;
      din_q      <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q] <= wr_addr;
      q_mask[wr_ptr_q] <= wr_mask;
      q_data[wr_ptr_q] <= wr_data;
    end
  end

  assign busy     = busy_q;
  assign full     = full_q;
  assign done     = done_q;
  assign error    = err_q;
  assign err_code = err_code_q;
  assign reconfig_to_pll = {37'b0, clk, rst_q, dwe_q, den_q, daddr_q, din_q};

endmodule

// File: tb/tb_mmcm_drp_cfg.sv
// Bench for mmcm_drp_cfg: DRP register-file / MMCM lock responder plus a queue-level RMW reference model.
module tb_mmcm_drp_cfg;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DRDY_TO = 255;
  localparam int unsigned LOCK_TO = 1000;

  typedef struct packed {
    logic [6:0]  a;
    logic [15:0] m;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, start = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_mask = '0, wr_data = '0;
  logic        busy, full, done, error;
  logic [1:0]  err_code;
  logic [63:0] to_pll, from_pll;
  logic [15:0] dout_r = '0;
  logic        drdy_r = 1'b0, locked_r = 1'b0;

  logic        den, dwe, rst_mmcm;
  logic [6:0]  daddr;
  logic [15:0] din;
  assign din      = to_pll[15:0];
  assign daddr    = to_pll[22:16];
  assign den      = to_pll[23];
  assign dwe      = to_pll[24];
  assign rst_mmcm = to_pll[25];
  assign from_pll = {46'b0, locked_r, drdy_r, dout_r};

  mmcm_drp_cfg #(.DEPTH(DEPTH), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_data(wr_data), .start(start), .busy(busy), .full(full), .done(done),
    .error(error), .err_code(err_code), .reconfig_to_pll(to_pll),
    .reconfig_from_pll(from_pll)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] dev_mem [128];
  logic [15:0] ref_mem [128];
  ent_t        refq [$];
  logic [22:0] wq [$];

  int   cyc = 0, pend = 0, viol = 0, done_cnt = 0, nrd = 0, hang_rd = 0;
  int   hang_cyc = 0, err_cyc = 0, lat_max = 3, lk = 0;
  bit   outstanding = 0, den_prev = 0, den_seen = 0, rst_seen = 0, wrote = 0;
  bit   corrupt = 0, lock_en = 1, err_prev = 0;
  logic [15:0] resp = '0;

  // DRP register file and MMCM lock responder
  always @(negedge clk) begin
    cyc++;
    if (drdy_r) begin drdy_r = 1'b0; outstanding = 0; end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin drdy_r = 1'b1; dout_r = resp; end
    end
    if (!busy) outstanding = 0;
    if (den) begin
      if (outstanding || den_prev) viol++;
      if (!rst_mmcm) viol++;
      outstanding = 1; den_seen = 1;
      if (dwe) begin
        dev_mem[daddr] = din;
        wq.push_back({daddr, din});
        wrote = 1; resp = '0;
        pend = $urandom_range(1, lat_max);
      end else begin
        nrd++;
        resp = (corrupt && wrote) ? 16'h0000 : dev_mem[daddr];
        if (nrd == hang_rd) hang_cyc = cyc;
        else pend = $urandom_range(1, lat_max);
      end
    end
    den_prev = den;
    if (rst_mmcm) rst_seen = 1;
    if (done) done_cnt++;
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
    if (rst_mmcm || !lock_en) begin locked_r = 1'b0; lk = 0; end
    else if (!locked_r) begin lk++; if (lk >= 10) locked_r = 1'b1; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    ent_t e;
    wr = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    step();
    wr = 1'b0;
    e.a = a; e.m = m; e.d = d;
    if (refq.size() < DEPTH) refq.push_back(e);
  endtask

  task automatic clear_mon();
    done_cnt = 0; den_seen = 0; rst_seen = 0; nrd = 0; wrote = 0;
  endtask

  task automatic do_start();
    clear_mon();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit poke);
    int i;
    i = 0;
    while (busy && i < budget) begin
      if (poke && i == 5) begin
        wr = 1'b1; start = 1'b1; wr_addr = 7'h55; wr_mask = '0; wr_data = 16'h1234;
        step(); wr = 1'b0; start = 1'b0;
      end else step();
      i++;
    end
    chk({tag, "_bound"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n_apply);
    logic [22:0] expq [$];
    ent_t e;
    logic [15:0] v;
    for (int i = 0; i < n_apply && refq.size() > 0; i++) begin
      e = refq.pop_front();
      v = (ref_mem[e.a] & e.m) | (e.d & ~e.m);
      ref_mem[e.a] = v;
      expq.push_back({e.a, v});
    end
    refq.delete();
    chk({tag, "_nwrites"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), {9'b0, wq[i]}, {9'b0, expq[i]});
    wq.delete();
  endtask

  task automatic empty_start(input string tag);
    do_start();
    chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    chk({tag, "_done1"}, {31'b0, done}, 32'd0);
    step();
    chk({tag, "_done2"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy2"}, {31'b0, busy}, 32'd0);
    step();
    chk({tag, "_den"}, {31'b0, den_seen}, 32'd0);
    chk({tag, "_rst"}, {31'b0, rst_seen}, 32'd0);
    chk({tag, "_err"}, {31'b0, error}, 32'd0);
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 128; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    repeat (3) step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_errcode", {30'b0, err_code}, 32'd0);
    chk("rst_drp", {6'b0, to_pll[25:0]}, 32'd0);
    chk("rst_hi", to_pll[58:27], 32'd0);
    rst_n = 1'b1;
    step();

    // single RMW
    dev_mem[8] = 16'hA3C2; ref_mem[8] = 16'hA3C2;
    push(7'h08, 16'hF000, 16'h0145);
    chk("t1_full", {31'b0, full}, 32'd0);
    do_start();
    wait_idle("t1", 400, 0);
    chk("t1_wval", {9'b0, wq[0]}, {9'b0, 7'h08, 16'hA145});
    check_writes("t1", 1);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", {31'b0, error}, 32'd0);

    // randomized RMW batches
    for (int r = 0; r < 4; r++) begin
      lat_max = $urandom_range(1, 6);
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++)
        push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
      chk($sformatf("rnd%0d_full", r), {31'b0, full}, {31'b0, (n == DEPTH)});
      do_start();
      wait_idle($sformatf("rnd%0d", r), 1500, 0);
      check_writes($sformatf("rnd%0d", r), DEPTH);
      chk($sformatf("rnd%0d_done", r), done_cnt, 1);
      chk($sformatf("rnd%0d_err", r), {31'b0, error}, 32'd0);
    end

    // queue fill, extra wr ignored, wr/start while busy ignored
    lat_max = 3;
    for (int k = 0; k < DEPTH; k++)
      push(7'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    chk("fill_full8", {31'b0, full}, 32'd1);
    push(7'h7F, 16'h0000, 16'hBEEF);
    chk("fill_full9", {31'b0, full}, 32'd1);
    do_start();
    wait_idle("fill", 1500, 1);
    check_writes("fill", DEPTH);
    chk("fill_done", done_cnt, 1);
    chk("fill_fullafter", {31'b0, full}, 32'd0);
    empty_start("fill_empty");

    // empty start
    empty_start("empty");

    // drdy timeout on the second read
    hang_rd = 2;
    push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    do_start();
    wait_idle("drdy", 1000, 0);
    hang_rd = 0;
    chk("drdy_error", {31'b0, error}, 32'd1);
    chk("drdy_code", {30'b0, err_code}, 32'd1);
    chk("drdy_rst", {31'b0, rst_mmcm}, 32'd0);
    chk("drdy_full", {31'b0, full}, 32'd0);
    chk("drdy_nodone", done_cnt, 0);
    chk("drdy_cycles", err_cyc - hang_cyc, DRDY_TO + 1);
    check_writes("drdy", 1);
    empty_start("drdy_flushed");

    // lock timeout, then recovery
    lock_en = 0;
    push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    do_start();
    wait_idle("lock", LOCK_TO + 300, 0);
    chk("lock_error", {31'b0, error}, 32'd1);
    chk("lock_code", {30'b0, err_code}, 32'd2);
    chk("lock_nodone", done_cnt, 0);
    check_writes("lock", 1);
    lock_en = 1;
    push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    do_start();
    chk("lock_clr_err", {31'b0, error}, 32'd0);
    chk("lock_clr_code", {30'b0, err_code}, 32'd0);
    wait_idle("lock2", 500, 0);
    check_writes("lock2", 1);
    chk("lock2_done", done_cnt, 1);

    // async reset during WR_WAIT
    for (int k = 0; k < DEPTH; k++)
      push(7'($urandom_range(0, 127)), 16'($urandom), 16'($urandom));
    chk("mid_full", {31'b0, full}, 32'd1);
    do_start();
    n = 0;
    while (wq.size() == 0 && n < 200) begin step(); n++; end
    chk("mid_wrseen", {31'b0, (wq.size() != 0)}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_drp", {6'b0, to_pll[25:0]}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_full0", {31'b0, full}, 32'd0);
    chk("mid_done", {31'b0, done}, 32'd0);
    chk("mid_err", {28'b0, error, 1'b0, err_code}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_writes("mid", 1);
    repeat (8) step();
    empty_start("mid_empty");

`ifdef MMCM_DRP_VERIFY_EN
    // corrupted readback after write
    corrupt = 1;
    dev_mem[8] = 16'hA3C2; ref_mem[8] = 16'hA3C2;
    push(7'h08, 16'hF000, 16'h0145);
    do_start();
    wait_idle("vf", 400, 0);
    corrupt = 0;
    chk("vf_error", {31'b0, error}, 32'd1);
    chk("vf_code", {30'b0, err_code}, 32'd3);
    chk("vf_rst", {31'b0, rst_mmcm}, 32'd0);
    chk("vf_nodone", done_cnt, 0);
    check_writes("vf", 1);
    empty_start("vf_empty");
`endif

    chk("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
